fifo_v3_sync: RTL and testbench

- Single-clock, register-based FIFO with a parameterisable depth.
- Holds in-flight tags, e.g. the AXI IDs that a serializer reflects back onto B/R responses.
- Provides full/empty/usage status, a synchronous flush, and an optional fall-through (zero-latency) mode.
- With DEPTH=0 it degenerates to a combinational pass-through.

---
 rtl/fifo_v3_sync_if.sv | 25 ++
 rtl/fifo_v3_sync.sv | 76 +++++++
 tb/tb_fifo_v3_sync.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_v3_sync_if.sv
// fifo_v3_sync_if: push/pop/status bundle between a FIFO and its user
interface fifo_v3_sync_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 8,
    parameter type dtype = logic [DATA_WIDTH-1:0],
    localparam int ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
);
    logic flush_i;
    logic testmode_i;
    logic full_o;
    logic empty_o;
    logic [ADDR_DEPTH-1:0] usage_o;
    dtype data_i;
    logic push_i;
    dtype data_o;
    logic pop_i;
    modport master (
        output flush_i, testmode_i, data_i, push_i, pop_i,
        input  full_o, empty_o, usage_o, data_o
    );
    modport slave (
        input  flush_i, testmode_i, data_i, push_i, pop_i,
        output full_o, empty_o, usage_o, data_o
    );
endinterface

// File: rtl/fifo_v3_sync.sv
// fifo_v3_sync: register-based single-clock FIFO with flush, usage and optional fall-through; FIFO_V3_ASSERT_EN compiles in simulation checks
module fifo_v3_sync #(
    parameter bit FALL_THROUGH = 1'b0,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 8,
    parameter type dtype = logic [DATA_WIDTH-1:0],
    localparam int ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input logic clk_i,
    input logic rst_i,
    fifo_v3_sync_if.slave bus
);
    if (DEPTH == 0) begin : g_pass
        assign bus.data_o = bus.data_i;
        assign bus.empty_o = ~bus.push_i;
        assign bus.full_o = ~bus.pop_i;
        assign bus.usage_o = '0;
    end else begin : g_fifo
        dtype r_mem [DEPTH];
        logic [ADDR_DEPTH-1:0] r_rd;
        logic [ADDR_DEPTH-1:0] r_wr;
        logic [ADDR_DEPTH:0] r_cnt;
        logic w_full;
        logic w_empty;
        logic w_ft;
        logic w_wr_en;
        logic w_rd_en;
        logic w_clk_en;
        assign w_full = r_cnt == (ADDR_DEPTH+1)'(DEPTH);
        assign w_ft = FALL_THROUGH && (r_cnt == '0) && bus.push_i;
        assign w_empty = (r_cnt == '0) && !w_ft;
        // a fall-through entry popped in the same cycle never touches storage
        assign w_wr_en = bus.push_i && !w_full && !(w_ft && bus.pop_i);
        assign w_rd_en = bus.pop_i && !w_empty && !w_ft;
        // storage clock enable; test mode keeps the gated clock running
        assign w_clk_en = w_wr_en || bus.testmode_i;
        assign bus.full_o = w_full;
        assign bus.empty_o = w_empty;
        assign bus.usage_o = r_cnt[ADDR_DEPTH-1:0];
        assign bus.data_o = w_ft ? bus.data_i : r_mem[r_rd];
        // pointers and fill count; flush wins over any push/pop
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_rd <= '0;
                r_wr <= '0;
                r_cnt <= '0;
            end else if (bus.flush_i) begin
                r_rd <= '0;
                r_wr <= '0;
                r_cnt <= '0;
            end else begin
                if (w_wr_en) r_wr <= (r_wr == ADDR_DEPTH'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
                if (w_rd_en) r_rd <= (r_rd == ADDR_DEPTH'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
                r_cnt <= r_cnt + (ADDR_DEPTH+1)'(w_wr_en) - (ADDR_DEPTH+1)'(w_rd_en);
            end
        end
        // entry storage, written at the write pointer on an accepted push
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            end else if (w_clk_en && w_wr_en && !bus.flush_i) begin
                r_mem[r_wr] <= bus.data_i;
            end
        end
    end
`ifdef FIFO_V3_ASSERT_EN
    if (DEPTH < 0 || DATA_WIDTH < 1) begin : g_bad_param
        $fatal(1, "fifo_v3_sync: DEPTH must be >= 0 and DATA_WIDTH >= 1");
    end
    // flag pushes into a full FIFO and pops from an empty one
    always @(posedge clk_i) begin
        if (!rst_i && bus.push_i && bus.full_o) $error("fifo_v3_sync: push while full");
        if (!rst_i && bus.pop_i && bus.empty_o) $error("fifo_v3_sync: pop while empty");
    end
`endif
endmodule

// File: tb/tb_fifo_v3_sync.sv
// tb_fifo_v3_sync: directed stimulus with a queue scoreboard on the DEPTH=4 FIFO plus fall-through and pass-through instances
module tb_fifo_v3_sync;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];
    logic [7:0] sb_exp;

    always #5 clk = ~clk;

    fifo_v3_sync_if #(.DATA_WIDTH(8), .DEPTH(4)) f4 ();
    fifo_v3_sync_if #(.DATA_WIDTH(8), .DEPTH(4)) ft ();
    fifo_v3_sync_if #(.DATA_WIDTH(8), .DEPTH(0)) f0 ();

    fifo_v3_sync #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)) u_d4 (.clk_i(clk), .rst_i(rst), .bus(f4));
    fifo_v3_sync #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) u_ft (.clk_i(clk), .rst_i(rst), .bus(ft));
    fifo_v3_sync #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(0)) u_d0 (.clk_i(clk), .rst_i(rst), .bus(f0));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [7:0] v);
        f4.push_i = 1'b1;
        f4.data_i = v;
        exp_q.push_back(v);
        cyc();
        f4.push_i = 1'b0;
    endtask

    task automatic pop4(input int n);
        f4.pop_i = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        f4.pop_i = 1'b0;
    endtask

    // monitor: every accepted pop must present the oldest expected entry
    always @(negedge clk) begin
        if (!rst && f4.pop_i && !f4.empty_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_pop: got %0h expected no entry", f4.data_o);
            end else begin
                sb_exp = exp_q.pop_front();
                if (f4.data_o !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_pop: got %0h expected %0h", f4.data_o, sb_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    logic [7:0] pt_d [4] = '{8'h3C, 8'hA5, 8'h00, 8'hFF};
    logic pt_push [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic pt_pop [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic pt_empty [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic pt_full [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        {f4.flush_i, f4.testmode_i, f4.push_i, f4.pop_i, f4.data_i} = '0;
        {ft.flush_i, ft.testmode_i, ft.push_i, ft.pop_i, ft.data_i} = '0;
        {f0.flush_i, f0.testmode_i, f0.push_i, f0.pop_i, f0.data_i} = '0;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_empty", 32'(f4.empty_o), 32'h1);
        chk("rst_full", 32'(f4.full_o), 32'h0);
        chk("rst_usage", 32'(f4.usage_o), 32'h0);
        chk("rst_data", 32'(f4.data_o), 32'h0);
        chk("rst_ft_empty", 32'(ft.empty_o), 32'h1);
        // fill to full, then drain in order
        push4(8'h0A);
        push4(8'h0B);
        push4(8'h0C);
        push4(8'h0D);
        chk("fill_full", 32'(f4.full_o), 32'h1);
        chk("fill_usage_wrap", 32'(f4.usage_o), 32'h0);
        chk("fill_head", 32'(f4.data_o), 32'h0A);
        pop4(4);
        chk("drain_empty", 32'(f4.empty_o), 32'h1);
        // full with push and pop: the push is lost
        push4(8'h01);
        push4(8'h02);
        push4(8'h03);
        push4(8'h04);
        f4.push_i = 1'b1;
        f4.pop_i = 1'b1;
        f4.data_i = 8'h0E;
        cyc();
        f4.push_i = 1'b0;
        f4.pop_i = 1'b0;
        chk("fullpp_usage", 32'(f4.usage_o), 32'h3);
        chk("fullpp_full", 32'(f4.full_o), 32'h0);
        pop4(3);
        chk("fullpp_empty", 32'(f4.empty_o), 32'h1);
        // pop while empty is ignored
        pop4(1);
        chk("pop_empty_usage", 32'(f4.usage_o), 32'h0);
        chk("pop_empty_empty", 32'(f4.empty_o), 32'h1);
        // half full, steady push+pop across pointer wrap
        push4(8'h11);
        push4(8'h22);
        f4.push_i = 1'b1;
        f4.pop_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            f4.data_i = 8'h31 + 8'(i);
            exp_q.push_back(f4.data_i);
            cyc();
            chk("half_usage", 32'(f4.usage_o), 32'h2);
        end
        f4.push_i = 1'b0;
        pop4(2);
        chk("half_empty", 32'(f4.empty_o), 32'h1);
        // flush overrides a concurrent push
        push4(8'h41);
        push4(8'h42);
        push4(8'h43);
        chk("pre_flush_usage", 32'(f4.usage_o), 32'h3);
        f4.flush_i = 1'b1;
        f4.push_i = 1'b1;
        f4.data_i = 8'h44;
        exp_q.delete();
        cyc();
        f4.flush_i = 1'b0;
        f4.push_i = 1'b0;
        chk("flush_empty", 32'(f4.empty_o), 32'h1);
        chk("flush_usage", 32'(f4.usage_o), 32'h0);
        // asynchronous reset between edges
        push4(8'h51);
        push4(8'h52);
        chk("pre_rst_usage", 32'(f4.usage_o), 32'h2);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_empty", 32'(f4.empty_o), 32'h1);
        chk("arst_usage", 32'(f4.usage_o), 32'h0);
        chk("arst_data", 32'(f4.data_o), 32'h0);
        rst = 1'b0;
        cyc();
        chk("arst_after_empty", 32'(f4.empty_o), 32'h1);
        // fall-through: push and pop into empty passes straight through
        ft.push_i = 1'b1;
        ft.pop_i = 1'b1;
        ft.data_i = 8'h05;
        #1;
        chk("ft_pp_data", 32'(ft.data_o), 32'h05);
        chk("ft_pp_empty", 32'(ft.empty_o), 32'h0);
        cyc();
        ft.push_i = 1'b0;
        ft.pop_i = 1'b0;
        #1;
        chk("ft_pp_usage", 32'(ft.usage_o), 32'h0);
        chk("ft_pp_empty_after", 32'(ft.empty_o), 32'h1);
        ft.push_i = 1'b1;
        ft.data_i = 8'h05;
        #1;
        chk("ft_push_data", 32'(ft.data_o), 32'h05);
        chk("ft_push_empty", 32'(ft.empty_o), 32'h0);
        cyc();
        ft.push_i = 1'b0;
        ft.data_i = 8'h77;
        #1;
        chk("ft_stored_usage", 32'(ft.usage_o), 32'h1);
        chk("ft_stored_data", 32'(ft.data_o), 32'h05);
        ft.pop_i = 1'b1;
        cyc();
        ft.pop_i = 1'b0;
        #1;
        chk("ft_drained", 32'(ft.empty_o), 32'h1);
        // pass-through with DEPTH=0
        for (int i = 0; i < 4; i++) begin
            f0.data_i = pt_d[i];
            f0.push_i = pt_push[i];
            f0.pop_i = pt_pop[i];
            #1;
            chk("pt_data", 32'(f0.data_o), 32'(pt_d[i]));
            chk("pt_empty", 32'(f0.empty_o), 32'(pt_empty[i]));
            chk("pt_full", 32'(f0.full_o), 32'(pt_full[i]));
            chk("pt_usage", 32'(f0.usage_o), 32'h0);
        end
        cyc();
        chk("sb_leftover", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
